// File: rtl/serial_receiver.sv
// Serial deserializer: samples din on bitTick while frameActive is high, checks framing and
// delivers width-bit words via a valid/ack register. Define SERIAL_RX_LSB_FIRST_EN for LSB-first assembly.
module serial_receiver #(
  parameter int width = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             din,
  input  logic             bitTick,
  input  logic             frameActive,
  input  logic             dataAck,
  output logic [width-1:0] dataOut,
  output logic             dataValid,
  output logic             rxBusy,
  output logic             rxDone,
  output logic             rxError,
  output logic             overrun,
  output logic [1:0]       o_dbg_state
);
  localparam int CW = $clog2(width + 1);
  localparam logic [CW-1:0] LAST = CW'(width);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SHIFT    = 2'd1,
    WAIT_END = 2'd2,
    FLUSH    = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CW-1:0]    r_count;
  logic [CW-1:0]    w_count_nxt;
  logic [CW-1:0]    w_count_inc;
  logic [width-1:0] r_shreg;
  logic [width-1:0] w_shreg_nxt;
  logic [width-1:0] w_shifted;
  logic [width-1:0] r_data;
  logic             r_valid;
  logic             r_done;
  logic             r_error;
  logic             r_overrun;
  logic             w_sample;
  logic             w_deliver;
  logic             w_reject;

  always_comb begin
    w_sample    = bitTick && frameActive;
    w_count_inc = r_count + CW'(1);
`ifdef SERIAL_RX_LSB_FIRST_EN
    w_shifted   = {din, r_shreg[width-1:1]};
`else
    w_shifted   = {r_shreg[width-2:0], din};
`endif
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_shreg_nxt = r_shreg;
    w_deliver   = 1'b0;
    w_reject    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_sample) begin
          w_shreg_nxt = w_shifted;
          w_count_nxt = CW'(1);
          w_state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (w_sample) begin
          w_shreg_nxt = w_shifted;
          w_count_nxt = w_count_inc;
          if (w_count_inc == LAST) w_state_nxt = WAIT_END;
        end else if (!frameActive) begin
          // Frame ended before a full word arrived.
          w_reject    = 1'b1;
          w_count_nxt = '0;
          w_state_nxt = IDLE;
        end
      end
      WAIT_END: begin
        if (!frameActive) begin
          w_deliver   = 1'b1;
          w_count_nxt = '0;
          w_state_nxt = IDLE;
        end else if (w_sample) begin
          w_reject    = 1'b1;
          w_count_nxt = '0;
          w_state_nxt = FLUSH;
        end
      end
      FLUSH: begin
        if (!frameActive) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Valid/ack: dataValid stays high until the edge after dataAck is seen with it high;
  // a delivery in that window overwrites dataOut and flags overrun unless dataAck is high on that edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_count   <= '0;
      r_shreg   <= '0;
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_done    <= 1'b0;
      r_error   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_count   <= w_count_nxt;
      r_shreg   <= w_shreg_nxt;
      r_done    <= w_deliver;
      r_error   <= w_reject;
      r_overrun <= w_deliver && r_valid && !dataAck;
      if (w_deliver) begin
        r_data  <= r_shreg;
        r_valid <= 1'b1;
      end else if (r_valid && dataAck) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign dataOut     = r_data;
  assign dataValid   = r_valid;
  assign rxBusy      = (r_state != IDLE);
  assign rxDone      = r_done;
  assign rxError     = r_error;
  assign overrun     = r_overrun;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_serial_receiver.sv
// Bench for serial_receiver: directed framing cases plus randomized frames, checked by a
// queue-based scoreboard and a monitor that tracks the expected valid/ack state.
module tb_serial_receiver;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         din = 1'b0;
  logic         bitTick = 1'b0;
  logic         frameActive = 1'b0;
  logic         dataAck = 1'b0;
  logic [W-1:0] dataOut;
  logic         dataValid;
  logic         rxBusy;
  logic         rxDone;
  logic         rxError;
  logic         overrun;
  logic [1:0]   dbg_state;

  serial_receiver #(.width(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .din         (din),
    .bitTick     (bitTick),
    .frameActive (frameActive),
    .dataAck     (dataAck),
    .dataOut     (dataOut),
    .dataValid   (dataValid),
    .rxBusy      (rxBusy),
    .rxDone      (rxDone),
    .rxError     (rxError),
    .overrun     (overrun),
    .o_dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  int           checks = 0;
  int           failures = 0;
  logic [W-1:0] exp_q[$];
  int           exp_err = 0;
  int           err_seen = 0;
  int           ovr_seen = 0;
  int           ack_mode = 0;   // 0 never, 1 random, 2 always
  logic         force_ack = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: apply inputs, wait for the edge, return 1 time unit after it.
  task automatic cyc(input logic fa, input logic tk, input logic d);
    frameActive = fa;
    bitTick     = tk;
    din         = d;
    @(posedge clk);
    #1;
  endtask

  function automatic logic stream_bit(input logic [W-1:0] w, input int i);
`ifdef SERIAL_RX_LSB_FIRST_EN
    return w[i];
`else
    return w[W-1-i];
`endif
  endfunction

  task automatic send_frame(input logic [W-1:0] word, input int nbits, input int gap_lo,
                            input int gap_hi, input int tail, input int low_extra,
                            input logic ack_on_del);
    if (nbits == W) exp_q.push_back(word);
    else if (nbits > 0) exp_err++;
    for (int i = 0; i < nbits; i++) begin
      int g;
      g = $urandom_range(gap_lo, gap_hi);
      repeat (g) cyc(1'b1, 1'b0, 1'($urandom));
      cyc(1'b1, 1'b1, (i < W) ? stream_bit(word, i) : 1'($urandom));
      if (i == 0) chk("busy_after_first_sample", {63'd0, rxBusy}, 64'd1);
      if (i == W) chk("long_err_on_extra_sample", {63'd0, rxError}, 64'd1);
    end
    repeat (tail) cyc(1'b1, 1'b0, 1'b0);
    force_ack = ack_on_del;
    cyc(1'b0, 1'b0, 1'b0);
    force_ack = 1'b0;
    if (nbits == W) begin
      chk("done_pulse", {63'd0, rxDone}, 64'd1);
      chk("data_at_done", {32'd0, dataOut}, {32'd0, word});
      chk("valid_at_done", {63'd0, dataValid}, 64'd1);
    end else if (nbits > 0) begin
      chk("no_done_bad_frame", {63'd0, rxDone}, 64'd0);
      if (nbits < W) chk("short_err_pulse", {63'd0, rxError}, 64'd1);
    end
    chk("idle_after_frame", {63'd0, rxBusy}, 64'd0);
    repeat (low_extra) cyc(1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: observes each edge's result at the following falling edge.
  initial begin : monitor
    logic         ack_prev;
    logic         rst_prev;
    logic         m_valid;
    logic [W-1:0] m_data;
    logic         exp_ovr;
    ack_prev = 1'b0;
    rst_prev = 1'b1;
    m_valid  = 1'b0;
    m_data   = '0;
    forever begin
      @(negedge clk);
      if (rst_prev) begin
        m_valid = 1'b0;
        m_data  = '0;
        chk("reset_outputs", {27'd0, dataOut, dataValid, rxBusy, rxDone, rxError, overrun}, 64'd0);
      end else begin
        exp_ovr = 1'b0;
        if (rxDone) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_delivery", 64'd1, 64'd0);
          end else begin
            m_data = exp_q.pop_front();
            chk("scoreboard_word", {32'd0, dataOut}, {32'd0, m_data});
          end
          exp_ovr = m_valid && !ack_prev;
          m_valid = 1'b1;
        end else if (m_valid && ack_prev) begin
          m_valid = 1'b0;
        end
        if (rxError) err_seen++;
        if (overrun) ovr_seen++;
        chk("overrun_flag", {63'd0, overrun}, {63'd0, exp_ovr});
        chk("valid_model", {63'd0, dataValid}, {63'd0, m_valid});
        chk("held_word", {32'd0, dataOut}, {32'd0, m_data});
      end
      rst_prev = reset;
      ack_prev = force_ack || (ack_mode == 2) || (ack_mode == 1 && $urandom_range(0, 3) == 0);
      dataAck  = ack_prev;
    end
  end

  initial begin : stimulus
    int o0;
    repeat (3) cyc(1'b0, 1'b0, 1'b0);
    chk("reset_state_busy", {63'd0, rxBusy}, 64'd0);
    chk("reset_state_data", {32'd0, dataOut}, 64'd0);
    reset = 1'b0;
    cyc(1'b0, 1'b0, 1'b0);

    // Basic frame, bitTick every 4 clocks.
    send_frame(32'hA5A51234, W, 3, 3, 0, 2, 1'b0);
    // Short frame: 16 bits.
    send_frame(32'h0000ABCD, 16, 0, 2, 1, 2, 1'b0);
    // Long frame: 33 samples, then a normal one.
    send_frame(32'h12345678, W + 1, 0, 1, 0, 1, 1'b0);
    send_frame(32'h0000FFFF, W, 0, 2, 0, 2, 1'b0);

    // Clear any held word, then two unacknowledged deliveries.
    ack_mode = 2;
    repeat (3) cyc(1'b0, 1'b0, 1'b0);
    ack_mode = 0;
    cyc(1'b0, 1'b0, 1'b0);
    chk("valid_cleared_by_ack", {63'd0, dataValid}, 64'd0);
    o0 = ovr_seen;
    send_frame(32'h11111111, W, 0, 1, 0, 0, 1'b0);
    send_frame(32'h22222222, W, 0, 1, 0, 2, 1'b0);
    chk("overrun_once", 64'(ovr_seen - o0), 64'd1);
    // Delivery with ack on the same edge while a word is held.
    o0 = ovr_seen;
    send_frame(32'h33333333, W, 0, 0, 1, 0, 1'b1);
    chk("valid_after_simul_ack", {63'd0, dataValid}, 64'd1);
    repeat (2) cyc(1'b0, 1'b0, 1'b0);
    chk("no_overrun_simul_ack", 64'(ovr_seen - o0), 64'd0);

    // Reset mid-frame while a word is still held.
    for (int i = 0; i < 10; i++) cyc(1'b1, 1'b1, 1'($urandom));
    reset = 1'b1;
    cyc(1'b1, 1'b1, 1'b0);
    chk("midframe_reset_outputs", {27'd0, dataOut, dataValid, rxBusy, rxDone, rxError, overrun}, 64'd0);
    reset = 1'b0;
    cyc(1'b0, 1'b0, 1'b0);
    send_frame(32'hDEADBEEF, W, 0, 3, 0, 1, 1'b0);
    send_frame(32'h00000001, W, 0, 2, 0, 1, 1'b0);

    // Randomized frames, including back-to-back and continuous bitTick.
    ack_mode = 1;
    for (int f = 0; f < 40; f++) begin
      int r;
      int nb;
      r  = $urandom_range(0, 9);
      nb = (r < 7) ? W : (r == 7) ? $urandom_range(1, W - 1) : $urandom_range(W + 1, W + 4);
      send_frame($urandom, nb, 0, $urandom_range(0, 3), $urandom_range(0, 2),
                 $urandom_range(0, 2), 1'($urandom_range(0, 3) == 0));
    end

    ack_mode = 2;
    repeat (5) cyc(1'b0, 1'b0, 1'b0);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    chk("error_pulse_count", 64'(err_seen), 64'(exp_err));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
